// File: rtl/punc_controller.sv
// Control FSM for the PUnC LC3 processor: sequences INIT/FETCH/DECODE/EXEC/EXEC2/HALT
// and decodes ir into datapath controls. Optional illegal-opcode trap: PUNC_ILLEGAL_TRAP_EN.
module punc_controller #(
  parameter logic [3:0] HALT_OPCODE = 4'b1111,
  parameter int         STATE_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ir,
  output logic               mem_wr_en,
  output logic [2:0]         mem_r_addr_sel,
  output logic               state2_STI,
  output logic               STR,
  output logic [2:0]         RF_wr_addr,
  output logic               RF_wr_en,
  output logic [2:0]         RF_r_addr_0,
  output logic [2:0]         RF_r_addr_1,
  output logic [1:0]         RF_w_data_sel,
  output logic               ir_ld,
  output logic               JMP_RET_JSRR,
  output logic               pc_ld,
  output logic               pc_clr,
  output logic               pc_up,
  output logic               add_const,
  output logic [1:0]         alu_sel,
  output logic               cc_en,
  output logic               n,
  output logic               z,
  output logic               p,
  output logic [10:0]        const_n,
`ifdef PUNC_ILLEGAL_TRAP_EN
  output logic               illegal,
`endif
  output logic [3:0]         SEXT_Select,
  output logic               halted,
  output logic [STATE_W-1:0] state_debug
);

  localparam logic [STATE_W-1:0] S_INIT   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_EXEC2  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(5);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_RSV0 = 4'b1000;
  localparam logic [3:0] OP_RSV1 = 4'b1101;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [3:0]         w_op;
  logic               w_trap;

  assign w_op    = ir[15:12];
  assign const_n = ir[10:0];

`ifdef PUNC_ILLEGAL_TRAP_EN
  assign w_trap = (w_op == OP_RSV0) || (w_op == OP_RSV1);

  logic r_illegal;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_trap)   r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign w_trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_op == HALT_OPCODE || w_trap) ? S_HALT : S_EXEC;
      S_EXEC:   w_next = (w_op == OP_LDI || w_op == OP_STI) ? S_EXEC2 : S_FETCH;
      S_EXEC2:  w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_INIT;
    endcase
  end

  always_comb begin
    mem_wr_en = 1'b0; mem_r_addr_sel = 3'd0; state2_STI = 1'b0; STR = 1'b0;
    RF_wr_addr = 3'd0; RF_wr_en = 1'b0; RF_r_addr_0 = 3'd0; RF_r_addr_1 = 3'd0;
    RF_w_data_sel = 2'd0; ir_ld = 1'b0; JMP_RET_JSRR = 1'b0; pc_ld = 1'b0;
    pc_clr = 1'b0; pc_up = 1'b0; add_const = 1'b0; alu_sel = 2'd0; cc_en = 1'b0;
    n = 1'b0; z = 1'b0; p = 1'b0; SEXT_Select = 4'b0000; halted = 1'b0;
    case (r_state)
      S_INIT:  pc_clr = 1'b1;
      S_FETCH: begin ir_ld = 1'b1; pc_up = 1'b1; end
      S_HALT:  halted = 1'b1;
      S_EXEC: begin
        case (w_op)
          OP_ADD, OP_AND: begin
            RF_r_addr_0 = ir[8:6]; RF_r_addr_1 = ir[2:0]; add_const = ir[5];
            SEXT_Select = 4'b1000; alu_sel = (w_op == OP_ADD) ? 2'd1 : 2'd2;
            RF_wr_addr = ir[11:9]; RF_wr_en = 1'b1; cc_en = 1'b1;
          end
          OP_NOT: begin
            RF_r_addr_0 = ir[8:6]; alu_sel = 2'd3; RF_wr_addr = ir[11:9];
            RF_wr_en = 1'b1; cc_en = 1'b1;
          end
          OP_BR: begin {n, z, p} = ir[11:9]; SEXT_Select = 4'b0010; end
          OP_JMP: begin RF_r_addr_0 = ir[8:6]; JMP_RET_JSRR = 1'b1; pc_ld = 1'b1; end
          OP_JSR: begin
            // R7 and PC update on the same edge, so JSRR through R7 reads the old link
            RF_wr_addr = 3'd7; RF_w_data_sel = 2'd1; RF_wr_en = 1'b1; pc_ld = 1'b1;
            if (ir[11]) SEXT_Select = 4'b0001;
            else begin RF_r_addr_0 = ir[8:6]; JMP_RET_JSRR = 1'b1; end
          end
          OP_LD: begin
            SEXT_Select = 4'b0010; mem_r_addr_sel = 3'd1; RF_w_data_sel = 2'd2;
            RF_wr_addr = ir[11:9]; RF_wr_en = 1'b1;
          end
          OP_LDR: begin
            RF_r_addr_0 = ir[8:6]; add_const = 1'b1; SEXT_Select = 4'b0100; alu_sel = 2'd1;
            mem_r_addr_sel = 3'd4; RF_w_data_sel = 2'd2; RF_wr_en = 1'b1;
          end
          OP_LEA: begin
            SEXT_Select = 4'b0010; RF_w_data_sel = 2'd3; RF_wr_addr = ir[11:9]; RF_wr_en = 1'b1;
          end
          OP_ST: begin RF_r_addr_0 = ir[11:9]; SEXT_Select = 4'b0010; mem_wr_en = 1'b1; end
          OP_STR: begin
            STR = 1'b1; RF_r_addr_0 = ir[8:6]; RF_r_addr_1 = ir[11:9]; add_const = 1'b1;
            SEXT_Select = 4'b0100; alu_sel = 2'd1; mem_wr_en = 1'b1;
          end
          OP_LDI, OP_STI: begin SEXT_Select = 4'b0010; mem_r_addr_sel = 3'd1; end
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (w_op == OP_LDI) begin
          mem_r_addr_sel = 3'd2; RF_w_data_sel = 2'd2; RF_wr_addr = ir[11:9]; RF_wr_en = 1'b1;
        end else begin
          state2_STI = 1'b1; RF_r_addr_0 = ir[11:9]; mem_wr_en = 1'b1;
        end
      end
      default: ;
    endcase
    // Reset overrides everything so an aborted instruction leaves no enable behind
    if (!rst) begin
      mem_wr_en = 1'b0; mem_r_addr_sel = 3'd0; state2_STI = 1'b0; STR = 1'b0;
      RF_wr_addr = 3'd0; RF_wr_en = 1'b0; RF_r_addr_0 = 3'd0; RF_r_addr_1 = 3'd0;
      RF_w_data_sel = 2'd0; ir_ld = 1'b0; JMP_RET_JSRR = 1'b0; pc_ld = 1'b0;
      pc_clr = 1'b0; pc_up = 1'b0; add_const = 1'b0; alu_sel = 2'd0; cc_en = 1'b0;
      n = 1'b0; z = 1'b0; p = 1'b0; SEXT_Select = 4'b0000; halted = 1'b0;
    end
  end

  assign state_debug = r_state;

endmodule

// File: tb/tb_punc_controller.sv
// Scoreboard bench for punc_controller: a per-phase instruction model pushes the expected
// control word each cycle; a negedge monitor pops and compares against the DUT outputs.
module tb_punc_controller;

`ifdef PUNC_ILLEGAL_TRAP_EN
  localparam int OW = 50;
`else
  localparam int OW = 49;
`endif

  localparam int PH_INIT = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_EXEC2 = 4, PH_HALT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        mem_wr_en, state2_STI, STR, RF_wr_en, ir_ld, JMP_RET_JSRR, pc_ld, pc_clr, pc_up;
  logic        add_const, cc_en, n, z, p, halted;
  logic [2:0]  mem_r_addr_sel, RF_wr_addr, RF_r_addr_0, RF_r_addr_1, state_debug;
  logic [1:0]  RF_w_data_sel, alu_sel;
  logic [10:0] const_n;
  logic [3:0]  SEXT_Select;
`ifdef PUNC_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] w_act;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          m_ill    = 1'b0;

  punc_controller dut (
    .clk(clk), .rst(rst), .ir(ir),
    .mem_wr_en(mem_wr_en), .mem_r_addr_sel(mem_r_addr_sel), .state2_STI(state2_STI),
    .STR(STR), .RF_wr_addr(RF_wr_addr), .RF_wr_en(RF_wr_en), .RF_r_addr_0(RF_r_addr_0),
    .RF_r_addr_1(RF_r_addr_1), .RF_w_data_sel(RF_w_data_sel), .ir_ld(ir_ld),
    .JMP_RET_JSRR(JMP_RET_JSRR), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_up(pc_up),
    .add_const(add_const), .alu_sel(alu_sel), .cc_en(cc_en), .n(n), .z(z), .p(p),
    .const_n(const_n),
`ifdef PUNC_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .SEXT_Select(SEXT_Select), .halted(halted), .state_debug(state_debug)
  );

  // clock/reset block
  always #5 clk = ~clk;

  assign w_act = {mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
                  RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR, pc_ld,
                  pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p, const_n,
                  SEXT_Select, halted, state_debug
`ifdef PUNC_ILLEGAL_TRAP_EN
                  , illegal
`endif
                  };

  function automatic logic traps(input logic [15:0] v);
`ifdef PUNC_ILLEGAL_TRAP_EN
    return (v[15:12] == 4'h8) || (v[15:12] == 4'hD);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: which controls each instruction raises in a given phase
  function automatic logic [OW-1:0] exp_vec(input int ph, input logic [15:0] v,
                                            input logic rst_v, input logic ill);
    logic       e_mw = 0, e_s2 = 0, e_str = 0, e_we = 0, e_irld = 0, e_jmp = 0, e_pcld = 0;
    logic       e_clr = 0, e_up = 0, e_ac = 0, e_cc = 0, e_halt = 0;
    logic [2:0] e_mrs = 0, e_wa = 0, e_r0 = 0, e_r1 = 0, e_nzp = 0, e_st;
    logic [1:0] e_wds = 0, e_alu = 0;
    logic [3:0] e_sx = 0;
    logic [OW-1:0] r;
    e_st = rst_v ? 3'(ph) : 3'd0;
    if (rst_v) begin
      if (ph == PH_INIT) e_clr = 1;
      if (ph == PH_FETCH) begin e_irld = 1; e_up = 1; end
      if (ph == PH_HALT) e_halt = 1;
      if (ph == PH_EXEC) begin
        case (v[15:12])
          4'h1, 4'h5: begin
            e_r0 = v[8:6]; e_r1 = v[2:0]; e_ac = v[5]; e_sx = 4'b1000;
            e_alu = (v[15:12] == 4'h1) ? 2'd1 : 2'd2; e_wa = v[11:9]; e_we = 1; e_cc = 1;
          end
          4'h9: begin e_r0 = v[8:6]; e_alu = 3; e_wa = v[11:9]; e_we = 1; e_cc = 1; end
          4'h0: begin e_nzp = v[11:9]; e_sx = 4'b0010; end
          4'hC: begin e_r0 = v[8:6]; e_jmp = 1; e_pcld = 1; end
          4'h4: begin
            e_wa = 7; e_wds = 1; e_we = 1; e_pcld = 1;
            if (v[11]) e_sx = 4'b0001; else begin e_r0 = v[8:6]; e_jmp = 1; end
          end
          4'h2: begin e_sx = 4'b0010; e_mrs = 1; e_wds = 2; e_wa = v[11:9]; e_we = 1; end
          4'h6: begin
            e_r0 = v[8:6]; e_ac = 1; e_sx = 4'b0100; e_alu = 1; e_mrs = 4; e_wds = 2; e_we = 1;
          end
          4'hE: begin e_sx = 4'b0010; e_wds = 3; e_wa = v[11:9]; e_we = 1; end
          4'h3: begin e_r0 = v[11:9]; e_sx = 4'b0010; e_mw = 1; end
          4'h7: begin
            e_str = 1; e_r0 = v[8:6]; e_r1 = v[11:9]; e_ac = 1; e_sx = 4'b0100; e_alu = 1; e_mw = 1;
          end
          4'hA, 4'hB: begin e_sx = 4'b0010; e_mrs = 1; end
          default: ;
        endcase
      end
      if (ph == PH_EXEC2) begin
        if (v[15:12] == 4'hA) begin e_mrs = 2; e_wds = 2; e_wa = v[11:9]; e_we = 1; end
        else begin e_s2 = 1; e_r0 = v[11:9]; e_mw = 1; end
      end
    end
    r = {e_mw, e_mrs, e_s2, e_str, e_wa, e_we, e_r0, e_r1, e_wds, e_irld, e_jmp, e_pcld,
         e_clr, e_up, e_ac, e_alu, e_cc, e_nzp, v[10:0], e_sx, e_halt, e_st
`ifdef PUNC_ILLEGAL_TRAP_EN
         , ill & rst_v
`endif
         };
`ifndef PUNC_ILLEGAL_TRAP_EN
    if (ill) r = r;
`endif
    return r;
  endfunction

  // monitor: pops one expectation per cycle the driver has described
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (w_act !== e) begin
        n_fail++;
        $display("FAIL ctrl_word t=%0t ir=%h act=%h exp=%h", $time, ir, w_act, e);
      end
    end
  end

  // driver tasks: called one time unit after a rising edge
  task automatic do_reset();
    rst = 1'b0; m_ill = 1'b0;
    exp_q.push_back(exp_vec(PH_INIT, ir, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(exp_vec(PH_INIT, ir, 1'b1, 1'b0));
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [15:0] v);
    ir = v;
    exp_q.push_back(exp_vec(PH_FETCH, v, 1'b1, m_ill));
    @(posedge clk); #1;
    exp_q.push_back(exp_vec(PH_DECODE, v, 1'b1, m_ill));
    @(posedge clk); #1;
    if (v[15:12] == 4'hF || traps(v)) begin
      m_ill = traps(v);
      for (int i = 0; i < 20; i++) begin
        exp_q.push_back(exp_vec(PH_HALT, v, 1'b1, m_ill));
        @(posedge clk); #1;
      end
      do_reset();
    end else begin
      exp_q.push_back(exp_vec(PH_EXEC, v, 1'b1, m_ill));
      @(posedge clk); #1;
      if (v[15:12] == 4'hA || v[15:12] == 4'hB) begin
        exp_q.push_back(exp_vec(PH_EXEC2, v, 1'b1, m_ill));
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic abort_store(input logic [15:0] v);
    ir = v;
    exp_q.push_back(exp_vec(PH_FETCH, v, 1'b1, m_ill));
    @(posedge clk); #1;
    exp_q.push_back(exp_vec(PH_DECODE, v, 1'b1, m_ill));
    @(posedge clk); #1;
    exp_q.push_back(exp_vec(PH_EXEC, v, 1'b1, m_ill));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_wr_en !== 1'b0 || state_debug !== 3'd0) begin
      n_fail++;
      $display("FAIL async_abort act=%b/%0d exp=0/0", mem_wr_en, state_debug);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b0;
    ir  = 16'h0000;
    @(posedge clk); #1;
    do_reset();
    run_instr(16'h1262);
    run_instr(16'hA405);
    run_instr(16'h0A03);
    run_instr(16'hB7FE);
    run_instr(16'h4811);
    run_instr(16'h41C0);
    run_instr(16'h6A85);
    run_instr(16'h7B7F);
    run_instr(16'h8123);
    run_instr(16'hD456);
    run_instr(16'hF025);
    abort_store(16'h3A10);
    for (int i = 0; i < 150; i++) begin
      v = 16'($urandom_range(0, 16'hFFFF));
      if (v[15:12] == 4'hF && (i % 40) != 0) v[15:12] = 4'h1;
      run_instr(v);
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
